// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access,
// favouring data but alternating on contention, with an access watchdog.
module mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_WORD       = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dreq, is_d, is_i, act, ok, bad;
  always_comb begin
    dreq = dREN | dWEN;
    is_d = state_q == DGRANT;
    is_i = state_q == IGRANT;
    act = is_d ? dreq : is_i && iREN;
    ok = act && ramstate == ACCESS;
    // a stuck access is force-completed so the requester never hangs
    bad = act && !ok && (ramstate == ERROR || cnt_q == CW'(TIMEOUT_CYCLES - 1));
    ramREN = is_d ? dREN & ~dWEN : is_i && iREN;
    ramWEN = is_d && dWEN;
    ramaddr = is_d ? daddr : is_i ? iaddr : '0;
    ramstore = is_d ? dstore : '0;
    dwait = !(is_d && (ok || bad));
    iwait = !(is_i && (ok || bad));
    dload = dwait ? '0 : ok ? ramload : ERR_WORD;
    iload = iwait ? '0 : ok ? ramload : ERR_WORD;
    state_d = state_q;
    last_d_d = last_d_q;
    err_d = err_q | bad;
    cnt_d = '0;
    if (state_q == IDLE)
      state_d = (dreq && iREN) ? (last_d_q ? IGRANT : DGRANT) : dreq ? DGRANT : iREN ? IGRANT : IDLE;
    else if (!act || ok || bad) begin
      state_d = IDLE;
      last_d_d = (ok || bad) ? is_d : last_d_q;
    end else
      cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_d_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign err = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a per-cycle ownership model.
module tb_mem_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] EW = 32'hBAD1BAD1;
  logic CLK = 0, RST = 1, iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [1:0] ramstate = 0;
  logic iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_WORD(EW)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err));
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  int m_own = 0, m_cnt = 0;
  bit m_last_d = 0, m_err = 0, m_act, m_ok, m_bad;
  logic s_iwait, s_dwait, s_ramREN, s_ramWEN, s_err;
  logic [31:0] s_iload, s_dload, s_ramaddr, s_ramstore;
  bit dq[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // owner: 0 none, 1 data, 2 fetch; m_cnt counts elapsed grant cycles
  task automatic cycle();
    bit dreq;
    @(negedge CLK);
    {s_iwait, s_dwait, s_ramREN, s_ramWEN, s_err} = {iwait, dwait, ramREN, ramWEN, err};
    {s_iload, s_dload, s_ramaddr, s_ramstore} = {iload, dload, ramaddr, ramstore};
    dreq = dREN | dWEN;
    m_act = m_own == 1 ? dreq : m_own == 2 ? iREN : 1'b0;
    m_ok = m_act && ramstate == 2;
    m_bad = m_act && !m_ok && (ramstate == 3 || m_cnt == TO - 1);
    chk("ramREN", ramREN, m_own == 1 ? (dREN && !dWEN) : m_own == 2 ? iREN : 1'b0);
    chk("ramWEN", ramWEN, m_own == 1 && dWEN);
    chk("ramaddr", ramaddr, m_own == 1 ? daddr : m_own == 2 ? iaddr : 32'h0);
    chk("ramstore", ramstore, m_own == 1 ? dstore : 32'h0);
    chk("dwait", dwait, !(m_own == 1 && (m_ok || m_bad)));
    chk("iwait", iwait, !(m_own == 2 && (m_ok || m_bad)));
    chk("dload", dload, m_own == 1 && m_ok ? ramload : m_own == 1 && m_bad ? EW : 32'h0);
    chk("iload", iload, m_own == 2 && m_ok ? ramload : m_own == 2 && m_bad ? EW : 32'h0);
    chk("err", err, m_err);
    if (m_ok || m_bad) dq.push_back(m_own == 1);
    @(posedge CLK);
    if (RST) begin
      m_own = 0; m_cnt = 0; m_last_d = 0; m_err = 0;
    end else if (m_own == 0) begin
      m_cnt = 0;
      m_own = (dreq && iREN) ? (m_last_d ? 2 : 1) : dreq ? 1 : iREN ? 2 : 0;
    end else if (!m_act || m_ok || m_bad) begin
      if (m_ok || m_bad) begin
        m_last_d = m_own == 1;
        m_err |= m_bad;
      end
      m_own = 0;
    end else m_cnt++;
    #1;
  endtask
  initial begin
    int k;
    @(posedge CLK); #1;
    cycle();
    chk("rst_iwait", s_iwait, 1); chk("rst_dwait", s_dwait, 1); chk("rst_err", s_err, 0);
    RST = 0;
    iREN = 1; iaddr = 32'h40; ramstate = 1;
    cycle(); chk("t1_ren_idle", s_ramREN, 0);
    cycle(); chk("t1_ren_g1", s_ramREN, 1);
    cycle(); chk("t1_iwait_g2", s_iwait, 1);
    ramstate = 2; ramload = 32'h2402000A;
    cycle(); chk("t1_iwait_g3", s_iwait, 0); chk("t1_iload", s_iload, 32'h2402000A);
    iREN = 0; ramstate = 0;
    cycle(); chk("t1_iwait_after", s_iwait, 1);
    iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h200; ramstate = 2; ramload = 32'h1234;
    dq.delete();
    for (int n = 0; n < 8; n++) cycle();
    chk("t3_count", dq.size(), 4);
    if (dq.size() == 4) begin
      chk("t3_g0", dq[0], 1); chk("t3_g1", dq[1], 0); chk("t3_g2", dq[2], 1); chk("t3_g3", dq[3], 0);
    end
    iREN = 0; dREN = 0;
    cycle();
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    cycle();
    cycle(); chk("t2_wen", s_ramWEN, 1); chk("t2_addr", s_ramaddr, 32'h100);
    chk("t2_store", s_ramstore, 32'hDEADBEEF); chk("t2_dwait", s_dwait, 0); chk("t2_iwait", s_iwait, 1);
    dWEN = 0;
    cycle();
    dREN = 1; ramstate = 1;
    cycle();
    k = 0;
    do begin cycle(); k++; end while (s_dwait !== 0 && k < 20);
    chk("t4_cycles", k, TO); chk("t4_dload", s_dload, EW);
    dREN = 0;
    cycle(); chk("t4_err", s_err, 1);
    iREN = 1; ramstate = 2;
    cycle(); cycle(); chk("t4_good_iwait", s_iwait, 0);
    iREN = 0;
    cycle(); chk("t4_err_sticky", s_err, 1);
    iREN = 1; ramstate = 3;
    cycle(); cycle(); chk("t5_iload", s_iload, EW);
    iREN = 0;
    cycle(); chk("t5_err", s_err, 1);
    dREN = 1; ramstate = 1;
    cycle(); cycle(); chk("t5_dgrant", s_ramREN, 1);
    RST = 1;
    cycle();
    RST = 0;
    cycle(); chk("t5_ren", s_ramREN, 0); chk("t5_wen", s_ramWEN, 0);
    chk("t5_dwait", s_dwait, 1); chk("t5_iwait", s_iwait, 1); chk("t5_err_clr", s_err, 0);
    dREN = 0;
    cycle();
    iREN = 1; ramstate = 1;
    cycle();
    dREN = 1;
    cycle(); cycle();
    iREN = 0;
    cycle(); chk("t6_ren_drop", s_ramREN, 0); chk("t6_iwait", s_iwait, 1);
    cycle(); chk("t6_idle", s_ramREN, 0);
    cycle(); chk("t6_dgrant", s_ramREN, 1);
    ramstate = 2;
    cycle();
    dREN = 0;
    cycle();
    for (int n = 0; n < 800; n++) begin
      int r;
      if (iREN && (s_iwait === 0 || $urandom % 16 == 0)) iREN = 0;
      else if (!iREN && $urandom % 3 == 0) begin iREN = 1; iaddr = $urandom; end
      if ((dREN || dWEN) && (s_dwait === 0 || $urandom % 16 == 0)) begin dREN = 0; dWEN = 0; end
      else if (!(dREN || dWEN) && $urandom % 3 == 0) begin
        r = $urandom % 3;
        dREN = r != 1; dWEN = r != 0; daddr = $urandom; dstore = $urandom;
      end
      r = $urandom % 20;
      ramstate = r < 5 ? 2'd2 : r == 5 ? 2'd3 : r < 13 ? 2'd1 : 2'd0;
      ramload = $urandom;
      RST = $urandom % 150 == 0;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-ported RAM between the instruction-fetch and data-memory request streams of the pipelined datapath.
It sits between the cache-side request ports (instruction read, data read/write) and the RAM port, and grants one requester at a time.
Data requests are favoured, but fetches cannot be starved. Each requester sees a wait/ready handshake, and a watchdog flags RAM accesses that never complete.

Parameters:
TIMEOUT_CYCLES, 64, cycles a grant may stay open without ramstate==ACCESS before it is force-completed with an error
ERR_WORD, 32'hBAD1BAD1, load data returned on a force-completed or ERROR access

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
iREN  input  1  instruction read request, held until iwait low
iaddr  input  32  instruction address
iwait  output  1  low for exactly the completing cycle of an instruction access
iload  output  32  instruction word, valid when iwait low
dREN  input  1  data read request
dWEN  input  1  data write request; wins if asserted with dREN
daddr  input  32  data address
dstore  input  32  write data
dwait  output  1  low for exactly the completing cycle of a data access
dload  output  32  read data, valid when dwait low
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  output  1  sticky error flag, cleared only by RST

Behaviour:
- The block uses one clock and one reset. Reset is synchronous and active-high: RST is sampled on the rising edge of CLK.
- The FSM has three states: IDLE, DGRANT and IGRANT. It also keeps a registered last_d bit (1 = last completed grant was data).
- Reset values:
  - state=IDLE, last_d=0, err=0, timeout counter=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, iload=0, dload=0.
- Transitions from IDLE, evaluated on each edge:
  - If a data request (dREN|dWEN) and iREN are both pending, go to IGRANT when last_d=1, otherwise to DGRANT.
  - If only a data request is pending, go to DGRANT.
  - If only iREN is pending, go to IGRANT.
  - If nothing is pending, stay in IDLE.
- Arbitration latency: a request first visible in IDLE during cycle N gets its grant state and RAM enables in cycle N+1. No RAM enable is ever driven in IDLE.
- In DGRANT, RAM outputs are driven combinationally from the data port:
  - ramWEN=dWEN.
  - ramREN=dREN&~dWEN.
  - ramaddr=daddr, ramstore=dstore.
- In IGRANT, RAM outputs are driven from the fetch port: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion happens in the cycle where, in the granted state, ramstate==ACCESS:
  - The granted wait goes low combinationally and its load equals ramload.
  - On the next edge the FSM returns to IDLE and last_d is updated (1 after DGRANT, 0 after IGRANT).
  - Minimum access is therefore 2 cycles (grant plus ACCESS in the same cycle after the IDLE cycle), and back-to-back accesses are separated by exactly one IDLE cycle.
- The non-granted wait stays high and its load stays 0. Loads are 0 whenever the corresponding wait is high.
- The timeout counter clears on entry to a grant state and increments each grant cycle without ACCESS.
- Error completion occurs when ramstate==ERROR, or when the counter equals TIMEOUT_CYCLES-1 without ACCESS. In that cycle:
  - The granted wait goes low and its load = ERR_WORD.
  - err is set on the next edge.
  - The FSM goes to IDLE.
  - A write in this case is considered not performed.
- A requester that drops its request mid-grant causes the FSM to return to IDLE on the next edge. RAM enables fall combinationally in the same cycle, no wait pulse is produced, and last_d is not updated.
- Address or data changes mid-grant are passed straight through. The requester must hold them stable until its wait goes low.
- RST asserted mid-grant aborts the access: the state returns to IDLE and all outputs take their reset values on that edge. No completion pulse is generated.
- ramstate BUSY or FREE in a grant state means keep waiting.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, RAM returns ACCESS on the 3rd grant cycle with ramload=0x2402000A -> ramREN rises 1 cycle after iREN; iwait low for exactly 1 cycle with iload=0x2402000A; state back to IDLE.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ACCESS on the 1st grant cycle -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dwait low 1 cycle; iwait stays 1.
- iREN and dREN asserted together and held through 4 completions with last_d=0 at start -> grant order D, I, D, I; each completion followed by one IDLE cycle.
- dREN=1 with ramstate stuck at BUSY and TIMEOUT_CYCLES=8 -> dwait low on the 8th grant cycle with dload=0xBAD1BAD1; err=1 from the next cycle and stays set across later good accesses until RST.
- ramstate=ERROR during IGRANT -> iload=0xBAD1BAD1, err set; RST asserted during a following DGRANT -> next cycle ramREN=ramWEN=0, both waits 1, err=0.
- iREN dropped after 2 grant cycles without ACCESS -> ramREN 0 in that same cycle; no iwait pulse; a pending dREN is granted on the edge after the return to IDLE.
